// File: rtl/ldpc_ber_seq.sv
`default_nettype none
// ============================================================================
// Module      : ldpc_ber_seq
// Description : LDPC BER test sequencer. Generates LFSR messages, drives an
//               external encoder/decoder pair, injects bit errors and keeps
//               pass/fail/timeout statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module ldpc_ber_seq #(
    parameter int NN    = 208,
    parameter int MM    = 168,
    parameter int CNT_W = 32
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [15:0]         cfg_frames,
    input  logic [31:0]         cfg_seed,
    input  logic [7:0]          cfg_num_err,
    input  logic [15:0]         cfg_timeout,
    output logic [NN-MM-1:0]    enc_msg_o,
    output logic                enc_load_o,
    input  logic                enc_valid_i,
    input  logic [NN-1:0]       enc_cword_i,
    output logic [NN-1:0]       dec_q0_o,
    output logic [NN-1:0]       dec_q1_o,
    output logic                dec_start_o,
    input  logic                dec_done_i,
    input  logic [NN-1:0]       dec_cword_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    frames_o,
    output logic [CNT_W-1:0]    pass_o,
    output logic [CNT_W-1:0]    fail_o,
    output logic [CNT_W-1:0]    tmo_o,
    output logic [CNT_W-1:0]    inj_bits_o
);

    localparam int c_K        = NN - MM;
    localparam int c_IW       = $clog2(NN);
    localparam int c_GEN_N    = (c_K + 31) / 32;
    localparam int c_GW       = (c_GEN_N > 1) ? $clog2(c_GEN_N) : 1;
    localparam logic [c_GW-1:0] c_GEN_LAST = c_GW'(c_GEN_N - 1);
    localparam logic [31:0]     c_TAPS     = 32'h8020_0003;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_GEN       = 3'd1;
    localparam logic [2:0] c_ST_ENC_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_INJ       = 3'd3;
    localparam logic [2:0] c_ST_DEC_START = 3'd4;
    localparam logic [2:0] c_ST_DEC_WAIT  = 3'd5;
    localparam logic [2:0] c_ST_CHECK     = 3'd6;
    localparam logic [2:0] c_ST_DONE      = 3'd7;

    logic [2:0]       r_state;
    logic [31:0]      r_lfsr;
    logic [c_K-1:0]   r_msg;
    logic [NN-1:0]    r_cword;
    logic [NN-1:0]    r_mask;
    logic [NN-1:0]    r_dec_q0;
    logic [NN-1:0]    r_dec_q1;
    logic             r_enc_load;
    logic             r_dec_start;
    logic [c_GW-1:0]  r_gen_cnt;
    logic [7:0]       r_draws;
    logic [16:0]      r_tmr;
    logic [16:0]      r_tmo_lim;
    logic [15:0]      r_cfg_frames;
    logic [7:0]       r_cfg_num_err;
    logic [CNT_W-1:0] r_frames;
    logic [CNT_W-1:0] r_pass;
    logic [CNT_W-1:0] r_fail;
    logic [CNT_W-1:0] r_tmo;
    logic [CNT_W-1:0] r_inj;

    logic [31:0]      w_lfsr_step;
    logic [c_K+31:0]  w_msg_cat;
    logic [c_IW-1:0]  w_idx;
    logic             w_idx_ok;
    logic [NN-1:0]    w_mask_nxt;
    logic [c_IW:0]    w_pop;
    logic             w_tmr_exp;
    logic [CNT_W-1:0] w_frames_inc;
    logic             w_last;

    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] v,
                                                   input logic [c_IW:0]    a);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(a);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_lfsr_step  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? c_TAPS : 32'h0);
    assign w_msg_cat    = {r_msg, r_lfsr};
    assign w_idx        = r_lfsr[c_IW-1:0];
    assign w_idx_ok     = ({1'b0, w_idx} < (c_IW+1)'(NN));
    assign w_mask_nxt   = r_mask | (w_idx_ok ? (NN'(1) << w_idx) : {NN{1'b0}});
    assign w_tmr_exp    = (r_tmr == r_tmo_lim - 17'd1);
    assign w_frames_inc = f_sat_inc(r_frames);
    assign w_last       = (w_frames_inc >= CNT_W'(r_cfg_frames));

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < NN; i++) begin
            w_pop = w_pop + (c_IW+1)'(w_mask_nxt[i]);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= c_ST_IDLE;
            r_lfsr        <= 32'h1;
            r_msg         <= '0;
            r_cword       <= '0;
            r_mask        <= '0;
            r_dec_q0      <= '0;
            r_dec_q1      <= '0;
            r_enc_load    <= 1'b0;
            r_dec_start   <= 1'b0;
            r_gen_cnt     <= '0;
            r_draws       <= '0;
            r_tmr         <= '0;
            r_tmo_lim     <= '0;
            r_cfg_frames  <= '0;
            r_cfg_num_err <= '0;
            r_frames      <= '0;
            r_pass        <= '0;
            r_fail        <= '0;
            r_tmo         <= '0;
            r_inj         <= '0;
        end else begin
            r_enc_load  <= 1'b0;
            r_dec_start <= 1'b0;
            if (r_state == c_ST_IDLE || r_state == c_ST_DONE) begin
                if (cfg_start && !cfg_stop) begin
                    r_lfsr        <= (cfg_seed == 32'h0) ? 32'h1 : cfg_seed;
                    r_cfg_frames  <= cfg_frames;
                    r_cfg_num_err <= cfg_num_err;
                    r_tmo_lim     <= (cfg_timeout == 16'h0) ? 17'h1_0000 : {1'b0, cfg_timeout};
                    r_frames      <= '0;
                    r_pass        <= '0;
                    r_fail        <= '0;
                    r_tmo         <= '0;
                    r_inj         <= '0;
                    r_mask        <= '0;
                    r_msg         <= '0;
                    r_gen_cnt     <= '0;
                    r_state       <= (cfg_frames == 16'h0) ? c_ST_DONE : c_ST_GEN;
                end
            end else if (cfg_stop) begin
                // Abort drops the frame in flight; no pulse is scheduled.
                r_state <= c_ST_DONE;
            end else begin
                case (r_state)
                    c_ST_GEN: begin
                        r_msg  <= w_msg_cat[c_K-1:0];
                        r_lfsr <= w_lfsr_step;
                        if (r_gen_cnt == c_GEN_LAST) begin
                            r_gen_cnt  <= '0;
                            r_enc_load <= 1'b1;
                            r_tmr      <= '0;
                            r_state    <= c_ST_ENC_WAIT;
                        end else begin
                            r_gen_cnt <= r_gen_cnt + c_GW'(1);
                        end
                    end
                    c_ST_ENC_WAIT: begin
                        if (enc_valid_i) begin
                            r_cword <= enc_cword_i;
                            r_mask  <= '0;
                            r_draws <= '0;
                            if (r_cfg_num_err == 8'h0) begin
                                r_dec_q0    <= {NN{1'b1}};
                                r_dec_q1    <= enc_cword_i;
                                r_dec_start <= 1'b1;
                                r_state     <= c_ST_DEC_START;
                            end else begin
                                r_state <= c_ST_INJ;
                            end
                        end else if (w_tmr_exp) begin
                            r_tmo    <= f_sat_inc(r_tmo);
                            r_frames <= w_frames_inc;
                            r_state  <= w_last ? c_ST_DONE : c_ST_GEN;
                        end else begin
                            r_tmr <= r_tmr + 17'd1;
                        end
                    end
                    c_ST_INJ: begin
                        // Out-of-range indices are redrawn next cycle without counting.
                        r_lfsr <= w_lfsr_step;
                        if (w_idx_ok) begin
                            r_mask  <= w_mask_nxt;
                            r_draws <= r_draws + 8'd1;
                            if (r_draws + 8'd1 == r_cfg_num_err) begin
                                r_inj       <= f_sat_add(r_inj, w_pop);
                                r_dec_q0    <= {NN{1'b1}};
                                r_dec_q1    <= r_cword ^ w_mask_nxt;
                                r_dec_start <= 1'b1;
                                r_state     <= c_ST_DEC_START;
                            end
                        end
                    end
                    c_ST_DEC_START: begin
                        r_tmr   <= '0;
                        r_state <= c_ST_DEC_WAIT;
                    end
                    c_ST_DEC_WAIT: begin
                        if (dec_done_i) begin
                            r_state <= c_ST_CHECK;
                        end else if (w_tmr_exp) begin
                            r_tmo    <= f_sat_inc(r_tmo);
                            r_frames <= w_frames_inc;
                            r_state  <= w_last ? c_ST_DONE : c_ST_GEN;
                        end else begin
                            r_tmr <= r_tmr + 17'd1;
                        end
                    end
                    c_ST_CHECK: begin
                        if (dec_cword_i == r_cword) begin
                            r_pass <= f_sat_inc(r_pass);
                        end else begin
                            r_fail <= f_sat_inc(r_fail);
                        end
                        r_frames <= w_frames_inc;
                        r_state  <= w_last ? c_ST_DONE : c_ST_GEN;
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign enc_msg_o   = r_msg;
    assign enc_load_o  = r_enc_load;
    assign dec_q0_o    = r_dec_q0;
    assign dec_q1_o    = r_dec_q1;
    assign dec_start_o = r_dec_start;
    assign busy_o      = (r_state != c_ST_IDLE) && (r_state != c_ST_DONE);
    assign done_o      = (r_state == c_ST_DONE);
    assign frames_o    = r_frames;
    assign pass_o      = r_pass;
    assign fail_o      = r_fail;
    assign tmo_o       = r_tmo;
    assign inj_bits_o  = r_inj;

endmodule
`default_nettype wire
